// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU control codes, RV32I opcode
// constants, the issue FSM state enum, and the decoded-instruction payload.
// Included by alu_issue and alu_issue_decode via import alu_pkg::*.
package alu_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CTRL_W = 4;

  // Control codes understood by the external ALU
  typedef enum logic [CTRL_W-1:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1110
  } alu_ctrl_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_e;

  // How the branch outcome is derived from the ALU response
  typedef enum logic [2:0] {
    BR_NONE,
    BR_EQ,   // taken when zero
    BR_NE,   // taken when not zero
    BR_LT,   // taken when res[0] set
    BR_GE    // taken when res[0] clear
  } br_kind_e;

  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    alu_ctrl_e         ctrl;
    br_kind_e          br;
    logic              illegal;
  } dec_t;

  function automatic logic br_taken(input br_kind_e br, input logic zero, input logic res0);
    case (br)
      BR_EQ:   return zero;
      BR_NE:   return !zero;
      BR_LT:   return res0;
      BR_GE:   return !res0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode for the ALU issue stage.
// Ports: instr/rs1_val/rs2_val in; dec out (operands, ALU code, branch kind,
// illegal flag). Illegal encodings come out with all operand/code fields zero.
// Branch decode is present only when ALU_ISSUE_BRANCH_EN is defined.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output dec_t        dec
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] shamt;
  logic        unused_rd;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];
  assign imm_i     = {{20{instr[31]}}, instr[31:20]};
  assign shamt     = 32'(instr[24:20]);
  assign unused_rd = ^instr[11:7];

  // Field decode; any encoding that is not matched stays illegal
  always_comb begin
    dec         = '0;
    dec.illegal = 1'b1;
    case (opcode)
      OPC_OP: begin
        dec.a = rs1_val;
        dec.b = rs2_val;
        if (funct7 == F7_BASE) begin
          dec.illegal = 1'b0;
          case (funct3)
            3'b000:  dec.ctrl = ALU_ADD;
            3'b001:  dec.ctrl = ALU_SLL;
            3'b010:  dec.ctrl = ALU_SLT;
            3'b011:  dec.ctrl = ALU_SLTU;
            3'b100:  dec.ctrl = ALU_XOR;
            3'b101:  dec.ctrl = ALU_SRL;
            3'b110:  dec.ctrl = ALU_OR;
            default: dec.ctrl = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec.illegal = 1'b0;
          dec.ctrl    = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec.illegal = 1'b0;
          dec.ctrl    = ALU_SRA;
        end
      end
      OPC_OP_IMM: begin
        dec.a = rs1_val;
        case (funct3)
          3'b001: begin
            dec.b       = shamt;
            dec.ctrl    = ALU_SLL;
            dec.illegal = (funct7 != F7_BASE);
          end
          3'b101: begin
            dec.b = shamt;
            if (funct7 == F7_BASE) begin
              dec.ctrl    = ALU_SRL;
              dec.illegal = 1'b0;
            end else if (funct7 == F7_ALT) begin
              dec.ctrl    = ALU_SRA;
              dec.illegal = 1'b0;
            end
          end
          default: begin
            dec.b       = imm_i;
            dec.illegal = 1'b0;
            case (funct3)
              3'b010:  dec.ctrl = ALU_SLT;
              3'b011:  dec.ctrl = ALU_SLTU;
              3'b100:  dec.ctrl = ALU_XOR;
              3'b110:  dec.ctrl = ALU_OR;
              3'b111:  dec.ctrl = ALU_AND;
              default: dec.ctrl = ALU_ADD;
            endcase
          end
        endcase
      end
`ifdef ALU_ISSUE_BRANCH_EN
      OPC_BRANCH: begin
        dec.a = rs1_val;
        dec.b = rs2_val;
        if (funct3 != 3'b010 && funct3 != 3'b011) begin
          dec.illegal = 1'b0;
          case (funct3)
            3'b000:  begin dec.ctrl = ALU_SUB;  dec.br = BR_EQ; end
            3'b001:  begin dec.ctrl = ALU_SUB;  dec.br = BR_NE; end
            3'b100:  begin dec.ctrl = ALU_SLT;  dec.br = BR_LT; end
            3'b101:  begin dec.ctrl = ALU_SLT;  dec.br = BR_GE; end
            3'b110:  begin dec.ctrl = ALU_SLTU; dec.br = BR_LT; end
            default: begin dec.ctrl = ALU_SLTU; dec.br = BR_GE; end
          endcase
        end
      end
`endif
      default: ;
    endcase
    // Illegal instructions present a zeroed operation to the ALU
    if (dec.illegal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: accepts one RV32I instruction with its register operands,
// drives an external combinational ALU, and returns the result (and branch
// outcome) over a valid/ready handshake. Sequence is IDLE -> EXEC -> DONE.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready, instr, rs1_val,
// rs2_val; alu_a/alu_b/alu_control to the ALU, alu_res/alu_zero back;
// out_valid/out_ready, out_result, out_taken, out_is_branch, out_illegal.
// Optional feature macro: ALU_ISSUE_BRANCH_EN enables branch decode.
module alu_issue
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_control,
  input  logic [XLEN-1:0] alu_res,
  input  logic            alu_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_taken,
  output logic            out_is_branch,
  output logic            out_illegal
);

  state_e          state_q, state_d;
  br_kind_e        br_q, br_d;
  dec_t            dec;
  logic            accept;
  logic [XLEN-1:0] alu_a_d, alu_b_d, out_result_d;
  logic [3:0]      alu_control_d;
  logic            out_valid_d, out_taken_d, out_illegal_d;

  alu_issue_decode u_decode (
    .instr   (instr),
    .rs1_val (32'(rs1_val)),
    .rs2_val (32'(rs2_val)),
    .dec     (dec)
  );

  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_ready && in_valid;

  // Next-state and next-register values
  always_comb begin
    state_d       = state_q;
    br_d          = br_q;
    alu_a_d       = alu_a;
    alu_b_d       = alu_b;
    alu_control_d = alu_control;
    out_result_d  = out_result;
    out_valid_d   = out_valid;
    out_taken_d   = out_taken;
    out_illegal_d = out_illegal;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          alu_a_d       = XLEN'(dec.a);
          alu_b_d       = XLEN'(dec.b);
          alu_control_d = dec.ctrl;
          br_d          = dec.br;
          out_illegal_d = dec.illegal;
          state_d       = ST_EXEC;
        end
      end
      ST_EXEC: begin
        out_result_d = out_illegal ? '0 : alu_res;
        out_taken_d  = br_taken(br_q, alu_zero, alu_res[0]);
        out_valid_d  = 1'b1;
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      br_q        <= BR_NONE;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      out_result  <= '0;
      out_valid   <= 1'b0;
      out_taken   <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      state_q     <= state_d;
      br_q        <= br_d;
      alu_a       <= alu_a_d;
      alu_b       <= alu_b_d;
      alu_control <= alu_control_d;
      out_result  <= out_result_d;
      out_valid   <= out_valid_d;
      out_taken   <= out_taken_d;
      out_illegal <= out_illegal_d;
    end
  end

`ifdef ALU_ISSUE_BRANCH_EN
  // Branch marker follows the accepted instruction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_is_branch <= 1'b0;
    end else if (accept) begin
      out_is_branch <= (dec.br != BR_NONE);
    end
  end
`else
  assign out_is_branch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue.sv
`timescale 1ns/1ps
module tb_alu_issue;

`ifdef ALU_ISSUE_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] res;
    logic        taken;
    logic        br;
    logic        ill;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr, rs1_val, rs2_val;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [3:0]  alu_control;
  logic        alu_zero;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_taken, out_is_branch, out_illegal;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  logic [31:0] last_res;
  logic [31:0] last_b;
  logic [3:0]  last_ctrl;
  logic        last_taken, last_br, last_ill;

  always #5 clk = ~clk;

  alu_issue #(.XLEN(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .instr         (instr),
    .rs1_val       (rs1_val),
    .rs2_val       (rs2_val),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_control   (alu_control),
    .alu_res       (alu_res),
    .alu_zero      (alu_zero),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_taken     (out_taken),
    .out_is_branch (out_is_branch),
    .out_illegal   (out_illegal)
  );

  // External ALU
  function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b0100: return a << b[4:0];
      4'b0101: return a >> b[4:0];
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: return $unsigned($signed(a) >>> b[4:0]);
      4'b1110: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_res  = alu_f(alu_control, alu_a, alu_b);
  assign alu_zero = (alu_res == 32'd0);

  // Reference model of one instruction
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    exp_t        e;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [3:0]  c;
    logic [31:0] b;
    logic        ok, br, tk;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    ok = 1'b0; br = 1'b0; tk = 1'b0; c = 4'd0; b = r2;
    case (op)
      7'h33: begin
        if (f7 == 7'h00) begin
          ok = 1'b1;
          case (f3)
            3'd0: c = 4'b0010; 3'd1: c = 4'b0100; 3'd2: c = 4'b0111; 3'd3: c = 4'b1110;
            3'd4: c = 4'b0011; 3'd5: c = 4'b0101; 3'd6: c = 4'b0001; default: c = 4'b0000;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) begin
          ok = 1'b1; c = 4'b0110;
        end else if (f7 == 7'h20 && f3 == 3'd5) begin
          ok = 1'b1; c = 4'b1000;
        end
      end
      7'h13: begin
        if (f3 == 3'd1) begin
          b = {27'd0, ins[24:20]}; c = 4'b0100; ok = (f7 == 7'h00);
        end else if (f3 == 3'd5) begin
          b = {27'd0, ins[24:20]};
          if (f7 == 7'h00) begin ok = 1'b1; c = 4'b0101; end
          else if (f7 == 7'h20) begin ok = 1'b1; c = 4'b1000; end
        end else begin
          b = {{20{ins[31]}}, ins[31:20]}; ok = 1'b1;
          case (f3)
            3'd2: c = 4'b0111; 3'd3: c = 4'b1110; 3'd4: c = 4'b0011;
            3'd6: c = 4'b0001; 3'd7: c = 4'b0000; default: c = 4'b0010;
          endcase
        end
      end
      7'h63: begin
        if (BR_EN && f3 != 3'd2 && f3 != 3'd3) begin
          ok = 1'b1; br = 1'b1;
          case (f3)
            3'd0: begin c = 4'b0110; tk = (r1 == r2); end
            3'd1: begin c = 4'b0110; tk = (r1 != r2); end
            3'd4: begin c = 4'b0111; tk = ($signed(r1) < $signed(r2)); end
            3'd5: begin c = 4'b0111; tk = ($signed(r1) >= $signed(r2)); end
            3'd6: begin c = 4'b1110; tk = (r1 < r2); end
            default: begin c = 4'b1110; tk = (r1 >= r2); end
          endcase
        end
      end
      default: ;
    endcase
    e = '0;
    if (ok) begin
      e.a = r1; e.b = b; e.ctrl = c; e.res = alu_f(c, r1, b); e.br = br; e.taken = tk;
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  // One full transaction: drive, follow through EXEC/DONE, hold for 'hold' cycles, release
  task automatic run_txn(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2, input int hold);
    exp_t e;
    int   n;
    sb.push_back(model(ins, r1, r2));
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    vectors++;
    if (!in_ready) begin
      miscompares++; $display("FAIL ready_wait: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1; instr = ins; rs1_val = r1; rs2_val = r2;
    @(posedge clk); #1;
    in_valid = 1'b0; instr = $urandom; rs1_val = $urandom; rs2_val = $urandom;
    e = sb[0];
    last_ctrl = alu_control; last_b = alu_b;
    vectors++;
    if ({alu_a, alu_b, alu_control} !== {e.a, e.b, e.ctrl}) begin
      miscompares++;
      $display("FAIL alu_drive instr=%h: a=%h b=%h ctrl=%b required a=%h b=%h ctrl=%b",
               ins, alu_a, alu_b, alu_control, e.a, e.b, e.ctrl);
    end
    vectors++;
    if ({in_ready, out_valid} !== 2'b00) begin
      miscompares++; $display("FAIL exec_flags instr=%h: in_ready/out_valid=%b required 00", ins, {in_ready, out_valid});
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++; $display("FAIL latency instr=%h: out_valid=%b two cycles after accept, required 1", ins, out_valid);
      n = 0;
      while (out_valid !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    end
    e = sb.pop_front();
    if (out_valid !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL out_timeout instr=%h: no out_valid", ins);
      return;
    end
    last_res = out_result; last_taken = out_taken; last_br = out_is_branch; last_ill = out_illegal;
    vectors++;
    if ({out_result, out_taken, out_is_branch, out_illegal} !== {e.res, e.taken, e.br, e.ill}) begin
      miscompares++;
      $display("FAIL result instr=%h r1=%h r2=%h: res=%h tk=%b br=%b ill=%b required res=%h tk=%b br=%b ill=%b",
               ins, r1, r2, out_result, out_taken, out_is_branch, out_illegal, e.res, e.taken, e.br, e.ill);
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0]; instr = 32'h002081B3;
      @(posedge clk); #1;
      vectors++;
      if ({out_valid, in_ready, out_result, out_taken, out_is_branch, out_illegal, alu_control, alu_a, alu_b} !==
          {2'b10, e.res, e.taken, e.br, e.ill, e.ctrl, e.a, e.b}) begin
        miscompares++;
        $display("FAIL hold cyc=%0d: valid=%b ready=%b res=%h ctrl=%b required valid=1 ready=0 res=%h ctrl=%b",
                 i, out_valid, in_ready, out_result, alu_control, e.res, e.ctrl);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++; $display("FAIL release instr=%h: out_valid/in_ready=%b required 01", ins, {out_valid, in_ready});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; rs1_val = '0; rs2_val = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({in_ready, out_valid, out_result, out_taken, out_is_branch, out_illegal, alu_a, alu_b, alu_control} !==
        {1'b1, 1'b0, 32'd0, 3'b000, 32'd0, 32'd0, 4'd0}) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b valid=%b res=%h a=%h b=%h ctrl=%b required ready=1 all others 0",
               in_ready, out_valid, out_result, alu_a, alu_b, alu_control);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_op();
    run_txn(32'h002081B3, 32'd5, 32'd7, 0);   // add x3,x1,x2
    vectors++;
    if ({last_ctrl, last_res, last_ill} !== {4'b0010, 32'd12, 1'b0}) begin
      miscompares++; $display("FAIL add_known: ctrl=%b res=%0d ill=%b required 0010 12 0", last_ctrl, last_res, last_ill);
    end
    run_txn(32'h402081B3, 32'd5, 32'd7, 0);            // sub -> negative
    run_txn(32'h0020A1B3, 32'hFFFFFFFF, 32'd1, 0);     // slt signed
    run_txn(32'h0020B1B3, 32'hFFFFFFFF, 32'd1, 0);     // sltu
    run_txn(32'h0020C1B3, 32'hA5A5A5A5, 32'h0F0F0F0F, 0); // xor
    run_txn(32'h002091B3, 32'h00000003, 32'd31, 0);    // sll by 31
    run_txn(32'h4020D1B3, 32'h80000010, 32'd4, 0);     // sra
    run_txn(32'h0020D1B3, 32'h80000010, 32'd4, 0);     // srl
    run_txn(32'h0020E1B3, 32'hF0000000, 32'h0000000F, 0); // or
    run_txn(32'h0020F1B3, 32'hFF00FF00, 32'h0FF00FF0, 0); // and
  endtask

  task automatic test_op_imm();
    run_txn(32'h4040D093, 32'h80000000, 32'd0, 0);     // srai x1,x1,4
    vectors++;
    if ({last_ctrl, last_b, last_res} !== {4'b1000, 32'd4, 32'hF8000000}) begin
      miscompares++; $display("FAIL srai_known: ctrl=%b b=%h res=%h required 1000 4 f8000000", last_ctrl, last_b, last_res);
    end
    run_txn(32'hFFF08093, 32'd10, 32'd0, 0);           // addi -1
    run_txn(32'h8000A093, 32'd0, 32'd0, 0);            // slti vs -2048
    run_txn(32'hFFF0B093, 32'd5, 32'd0, 0);            // sltiu vs 0xFFFFFFFF
    run_txn(32'h01F09093, 32'd1, 32'd0, 0);            // slli 31
    run_txn(32'h0040D093, 32'h80000000, 32'd0, 0);     // srli 4
    run_txn(32'h7FF0E093, 32'h12340000, 32'd0, 0);     // ori
  endtask

  task automatic test_branch();
    run_txn(32'h00209463, 32'd9, 32'd9, 0);            // bne equal
    vectors++;
    if (BR_EN ? ({last_ctrl, last_br, last_taken, last_ill} !== {4'b0110, 1'b1, 1'b0, 1'b0})
              : ({last_ill, last_res, last_taken} !== {1'b1, 32'd0, 1'b0})) begin
      miscompares++; $display("FAIL bne_eq_known: ctrl=%b br=%b tk=%b ill=%b res=%h", last_ctrl, last_br, last_taken, last_ill, last_res);
    end
    run_txn(32'h00209463, 32'd9, 32'd3, 0);            // bne differ
    vectors++;
    if (last_taken !== BR_EN) begin
      miscompares++; $display("FAIL bne_ne_known: taken=%b required %b", last_taken, BR_EN);
    end
    run_txn(32'h00208463, 32'd4, 32'd4, 0);            // beq
    run_txn(32'h0020C463, 32'hFFFFFFFF, 32'd1, 0);     // blt
    run_txn(32'h0020D463, 32'hFFFFFFFF, 32'd1, 0);     // bge
    run_txn(32'h0020E463, 32'hFFFFFFFF, 32'd1, 0);     // bltu
    run_txn(32'h0020F463, 32'hFFFFFFFF, 32'd1, 0);     // bgeu
    run_txn(32'h0020A463, 32'd1, 32'd2, 0);            // funct3 010 -> illegal
  endtask

  task automatic test_illegal();
    run_txn(32'h0000007F, 32'hDEADBEEF, 32'h12345678, 0);
    vectors++;
    if ({last_ill, last_res, last_ctrl, last_taken} !== {1'b1, 32'd0, 4'b0000, 1'b0}) begin
      miscompares++; $display("FAIL illegal_known: ill=%b res=%h ctrl=%b tk=%b required 1 0 0000 0", last_ill, last_res, last_ctrl, last_taken);
    end
    run_txn(32'h022081B3, 32'd5, 32'd7, 0);            // OP funct7 0000001
    run_txn(32'h40409093, 32'd5, 32'd0, 0);            // slli with funct7 0100000
    run_txn(32'h2040D093, 32'd5, 32'd0, 0);            // srli with bad funct7
  endtask

  task automatic test_backpressure();
    run_txn(32'h002081B3, 32'd100, 32'd23, 5);
  endtask

  task automatic test_reset_exec();
    bit seen;
    in_valid = 1'b1; instr = 32'h002081B3; rs1_val = 32'd1; rs2_val = 32'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    vectors++;
    if ({in_ready, out_valid, alu_control, out_result} !== {1'b1, 1'b0, 4'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_in_exec: ready=%b valid=%b ctrl=%b res=%h required 1 0 0000 0", in_ready, out_valid, alu_control, out_result);
    end
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++; $display("FAIL discarded_op: out_valid seen=%b required 0", seen);
    end
    run_txn(32'h0020C1B3, 32'h0000FFFF, 32'h00FF00FF, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins;
    logic [6:0]  f7;
    for (int k = 0; k < 30; k++) begin
      if (k[0]) begin
        f7 = (($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00);
        ins = {f7, 5'd2, 5'd1, 3'($urandom_range(0, 7)), 5'd3, 7'h33};
      end else begin
        ins = $urandom;
        ins[6:0] = 7'h13;
      end
      run_txn(ins, $urandom, $urandom, k % 3);
    end
  endtask

  initial begin
    test_reset();
    test_op();
    test_op_imm();
    test_branch();
    test_illegal();
    test_backpressure();
    test_reset_exec();
    test_back_to_back();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
